// File: rtl/rat_path_player_pkg.sv
// Shared definitions for the rat solver path-replay stage: direction codes,
// replay FSM states and the default maze coordinate width.
package rat_path_player_pkg;

  localparam int COORD_W_DEF = 4;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT,
    ST_FETCH,
    ST_MOVE,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/rat_path_player_coord_step.sv
// Combinational single-step move: applies one direction code to (x, y) and
// flags a step that would leave the maze via the carry/borrow bit.
module coord_step
  import rat_path_player_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic               out_of_range
);

  logic [COORD_W:0] sum;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    next_x = x;
    next_y = y;
    sum    = '0;
    unique case (dir)
      DIR_RIGHT: sum = {1'b0, x} + (COORD_W+1)'(1);
      DIR_DOWN:  sum = {1'b0, y} + (COORD_W+1)'(1);
      DIR_LEFT:  sum = {1'b0, x} - (COORD_W+1)'(1);
      DIR_UP:    sum = {1'b0, y} - (COORD_W+1)'(1);
      default:   sum = '0;
    endcase
    // The extra top bit is the carry on 15+1 and the borrow on 0-1.
    out_of_range = sum[COORD_W];
    if (dir[0]) next_y = sum[COORD_W-1:0];
    else        next_x = sum[COORD_W-1:0];
  end

endmodule

// File: rtl/rat_path_player.sv
// Drains the solver direction queue one move at a time, replaying it into
// absolute cells presented on a valid/ready port, with goal and range flags.
module rat_path_player
  import rat_path_player_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         q_out,
  input  logic               finishq,
  output logic               dequeue,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               pos_valid,
  input  logic               pos_ready,
  output logic [CNT_W-1:0]   move_count,
  output logic               busy,
  output logic               done,
  output logic               at_goal,
  output logic               err
);

  state_t             state, state_nxt;
  logic [1:0]         dir_q;
  logic               launch;
  logic [COORD_W-1:0] step_x, step_y;
  logic               step_oor;

  coord_step #(.COORD_W(COORD_W)) u_step (
    .x            (x_out),
    .y            (y_out),
    .dir          (dir_q),
    .next_x       (step_x),
    .next_y       (step_y),
    .out_of_range (step_oor)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    dequeue   = 1'b0;
    pos_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      ST_IDLE: if (start) begin
        launch    = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        busy      = 1'b1;
        pos_valid = 1'b1;
        if (pos_ready) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (finishq) begin
          state_nxt = ST_DONE;
        end else begin
          dequeue   = 1'b1;
          state_nxt = ST_MOVE;
        end
      end
      ST_MOVE: begin
        busy      = 1'b1;
        state_nxt = step_oor ? ST_ERR : ST_EMIT;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          launch    = 1'b1;
          state_nxt = ST_EMIT;
        end
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) begin
          launch    = 1'b1;
          state_nxt = ST_EMIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign at_goal = done && (&x_out) && (&y_out);

  // Position, move counter and latched direction; an illegal step leaves x/y untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out      <= '0;
      y_out      <= '0;
      move_count <= '0;
      dir_q      <= DIR_RIGHT;
    end else begin
      if (launch) begin
        x_out      <= '0;
        y_out      <= '0;
        move_count <= '0;
      end
      if (dequeue) dir_q <= q_out;
      if (state == ST_MOVE && !step_oor) begin
        x_out <= step_x;
        y_out <= step_y;
        if (move_count != '1) move_count <= move_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rat_path_player.sv
// Randomized self-checking bench for rat_path_player against a queue-walk
// reference model of the replayed path.
module tb_rat_path_player;

  localparam int CW   = 4;
  localparam int NW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    q_out;
  logic          finishq;
  logic          dequeue;
  logic [CW-1:0] x_out, y_out;
  logic          pos_valid;
  logic          pos_ready = 1'b0;
  logic [NW-1:0] move_count;
  logic          busy, done, at_goal, err;

  rat_path_player #(.COORD_W(CW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .q_out      (q_out),
    .finishq    (finishq),
    .dequeue    (dequeue),
    .x_out      (x_out),
    .y_out      (y_out),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .move_count (move_count),
    .busy       (busy),
    .done       (done),
    .at_goal    (at_goal),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Solver queue stand-in
  logic [1:0] dirs [0:63];
  int         qlen = 0;
  int         idx = 0;
  logic       q_clear = 1'b0;

  assign finishq = (idx >= qlen);
  assign q_out   = (idx < qlen) ? dirs[idx] : 2'b00;

  always @(posedge clk) begin
    if (q_clear)      idx <= 0;
    else if (dequeue) idx <= idx + 1;
  end

  // Consumer: drives pos_ready, records accepted cells, counts dequeues
  logic [2*CW-1:0] cells [$];
  int              deq_cnt = 0;
  int              mode = 0;
  int              hold = 0;
  logic            pend = 1'b0;
  logic [2*CW-1:0] pend_xy = '0;

  always @(negedge clk) begin
    if (!pos_valid) begin
      hold      = 0;
      pos_ready = (mode == 0);
    end else begin
      case (mode)
        0:       pos_ready = 1'b1;
        1:       pos_ready = 1'($urandom % 2);
        default: pos_ready = (hold >= 5);
      endcase
      hold++;
    end
    if (dequeue) deq_cnt++;
    if (pos_valid && pend) check("hold_xy", 32'({x_out, y_out}), 32'(pend_xy));
    if (pos_valid && pos_ready) begin
      cells.push_back({x_out, y_out});
      pend = 1'b0;
    end else if (pos_valid) begin
      pend    = 1'b1;
      pend_xy = {x_out, y_out};
    end else begin
      pend = 1'b0;
    end
  end

  // Reference model: walk the direction list with plain integer coordinates
  logic [2*CW-1:0] exp_cells [$];
  int              exp_deq, exp_moves;
  bit              exp_err;

  function automatic void model();
    int cx = 0, cy = 0, nx, ny;
    exp_cells.delete();
    exp_cells.push_back('0);
    exp_err   = 1'b0;
    exp_moves = 0;
    exp_deq   = qlen;
    for (int i = 0; i < qlen; i++) begin
      nx = cx;
      ny = cy;
      case (dirs[i])
        2'd0: nx = cx + 1;
        2'd1: ny = cy + 1;
        2'd2: nx = cx - 1;
        default: ny = cy - 1;
      endcase
      if (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC) begin
        exp_err = 1'b1;
        exp_deq = i + 1;
        break;
      end
      cx = nx;
      cy = ny;
      exp_moves++;
      exp_cells.push_back({CW'(cx), CW'(cy)});
    end
  endfunction

  // Random route; a legal route flips any escaping step to its opposite
  task automatic gen(input int len, input bit legal);
    int cx = 0, cy = 0;
    logic [1:0] d;
    qlen = len;
    for (int i = 0; i < len; i++) begin
      d = 2'($urandom % 4);
      if (legal && ((d == 2'd0 && cx == MAXC) || (d == 2'd1 && cy == MAXC) ||
                    (d == 2'd2 && cx == 0)    || (d == 2'd3 && cy == 0)))
        d = d ^ 2'b10;
      case (d)
        2'd0: cx++;
        2'd1: cy++;
        2'd2: cx--;
        default: cy--;
      endcase
      dirs[i] = d;
    end
  endtask

  task automatic launch();
    @(negedge clk);
    q_clear = 1'b1;
    @(negedge clk);
    q_clear = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int rmode, input bit glitch);
    int base = cells.size();
    int bdeq = deq_cnt;
    int ncells;
    bit fin = 1'b0;
    bit glitched = 1'b0;
    logic [2*CW-1:0] last;
    mode = rmode;
    model();
    launch();
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      #1;
      if (done || err) fin = 1'b1;
      if (glitch && !glitched && pos_valid && (cells.size() - base) >= 2) begin
        start    = 1'b1;
        glitched = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
      end
    end
    check({tag, "_finished"}, 32'(fin), 32'd1);
    ncells = cells.size() - base;
    check({tag, "_ncells"}, ncells, exp_cells.size());
    for (int i = 0; i < ncells && i < exp_cells.size(); i++)
      check({tag, "_cell"}, 32'(cells[base + i]), 32'(exp_cells[i]));
    last = exp_cells[exp_cells.size() - 1];
    check({tag, "_moves"}, 32'(move_count), exp_moves);
    check({tag, "_deq"}, deq_cnt - bdeq, exp_deq);
    check({tag, "_done"}, 32'(done), 32'(!exp_err));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_goal"}, 32'(at_goal), 32'(!exp_err && last == '1));
    check({tag, "_xy"}, 32'({x_out, y_out}), 32'(last));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},     32'(x_out), 0);
    check({tag, "_y"},     32'(y_out), 0);
    check({tag, "_cnt"},   32'(move_count), 0);
    check({tag, "_flags"}, 32'({dequeue, pos_valid, busy, done, at_goal, err}), 0);
  endtask

  task automatic reset_mid_run();
    int  bdeq;
    bit  hit = 1'b0;
    gen(8, 1'b1);
    mode = 0;
    bdeq = deq_cnt;
    launch();
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (deq_cnt - bdeq == 3) hit = 1'b1;
    end
    check("rstmid_reached", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rstmid");
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    qlen = 30;
    for (int i = 0; i < 30; i++) dirs[i] = (i < 15) ? 2'd0 : 2'd1;
    run("straight", 0, 1'b0);

    qlen = 2; dirs[0] = 2'd0; dirs[1] = 2'd1;
    run("backpressure", 2, 1'b0);

    qlen = 1; dirs[0] = 2'd2;
    run("oor", 0, 1'b0);

    qlen = 0;
    run("empty", 0, 1'b0);

    reset_mid_run();
    gen(10, 1'b1);
    run("after_rst", 0, 1'b0);

    gen(10, 1'b1);
    run("start_busy", 2, 1'b1);

    for (int t = 0; t < 12; t++) begin
      gen(int'($urandom_range(0, 40)), 1'($urandom % 2));
      run("rnd", int'($urandom % 2), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rat_path_player.md
# rat_path_player

Downstream stage of the intelligent-rat solver. Once the solver has written the found route into its 2-bit direction queue, this block drains the queue one move at a time. Starting from the maze origin, it replays each direction into absolute (x, y) coordinates and presents every visited cell on a valid/ready output port for display or logging. It also counts moves, reports whether replay ended on the goal cell, and flags any move that would leave the maze.

## Interface
- `COORD_W`, default 4: coordinate width; the maze is 2^COORD_W × 2^COORD_W.
- `CNT_W`, default 8: move-counter width.

- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `start`: input, 1 bit. Begin replay; sampled only in IDLE, DONE or ERR.
- `q_out`: input, 2 bits. Direction at the solver queue front; valid combinationally while `finishq` is low.
- `finishq`: input, 1 bit. Queue exhausted; no more moves.
- `dequeue`: output, 1 bit. One-cycle pulse; advances the solver queue front on the same edge.
- `x_out`, `y_out`: output, COORD_W bits each. Current cell coordinates.
- `pos_valid`: output, 1 bit. `x_out`/`y_out` hold a cell to be consumed.
- `pos_ready`: input, 1 bit. Consumer accepts the cell.
- `move_count`: output, CNT_W bits. Moves applied since `start`; saturates at all-ones.
- `busy`: output, 1 bit. High in every state except IDLE, DONE and ERR.
- `done`: output, 1 bit. Level signal: replay finished cleanly.
- `at_goal`: output, 1 bit. Level signal: `done` is high and the final cell is (max, max).
- `err`: output, 1 bit. Level signal: a move left the maze.

## Operation
- Direction codes (shared with the solver):
  - 00: x+1 (right)
  - 01: y+1 (down)
  - 10: x−1 (left)
  - 11: y−1 (up)
- States:
  - **IDLE**: `start` → clear x, y and `move_count` to 0, go to EMIT. The origin (0,0) is emitted first.
  - **EMIT**: `pos_valid`=1 with x, y held stable. On `pos_valid && pos_ready` → FETCH.
  - **FETCH**:
    - `finishq`=1 → DONE; no dequeue is issued.
    - Otherwise → assert `dequeue` for this cycle, latch `q_out` into the direction register, go to MOVE.
  - **MOVE**: compute the next coordinate with a COORD_W+1-bit add/subtract.
    - Carry/borrow out → ERR. x and y remain at the last legal cell.
    - Otherwise → update x or y, increment `move_count` (saturating), go to EMIT.
  - **DONE**: `done`=1; `at_goal` = (x, y both all-ones). `start` → restart exactly as from IDLE.
  - **ERR**: `err`=1; `dequeue` is never asserted. `start` → restart as from IDLE.
- `start` is ignored while `busy` is high.
- The solver must not modify the queue while `busy` is high.
- `rst` is honoured in any state, including mid-handshake. The block goes to IDLE and `dequeue` is 0 in the cycle after reset.
- No wrap-around: 15+1 and 0−1 (COORD_W=4) are errors and are never truncated.

## Timing
- Reset values:
  - state = IDLE
  - `x_out`, `y_out` = 0
  - `move_count` = 0
  - `dequeue`, `pos_valid`, `busy`, `done`, `at_goal`, `err` = 0
- Latency per move with `pos_ready` tied high: FETCH, MOVE, EMIT = 3 cycles per cell.
  - First cell: `pos_valid` rises 1 cycle after `start` is sampled.
- `pos_valid` stays high until accepted. x and y must not change while `pos_valid` is high.
- `dequeue` is high only in FETCH, for exactly one cycle per move.
  - The number of `dequeue` pulses equals `move_count` on clean completion.
- `done`, `at_goal` and `err` change only on a state transition, and clear on the cycle after `start` is accepted.

## Structure
- Shared package:
  - direction encoding constants: DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP
  - state enum
  - the COORD_W default shared with the maze memory and coordinate registers
- One natural sub-module, `coord_step`: combinational. Inputs are x, y and the direction; outputs are next x, next y and `out_of_range`.
  - It reuses the same carry-based range check as the solver.
  - The FSM, counters and handshake stay in the top module.

## Test plan
- **Straight path**: queue {00×15, 01×15}, `pos_ready`=1.
  - Expect 31 cells emitted: (0,0)…(15,0)…(15,15).
  - Expect `move_count`=30, 30 `dequeue` pulses, `done`=1, `at_goal`=1.
- **Backpressure**: queue {00, 01}, with `pos_ready` held low for 5 cycles on each cell.
  - Each cell must be held stable with `pos_valid` high for all 5 cycles.
  - Expect exactly 2 `dequeue` pulses and final cell (1,1).
- **Out of range**: queue {10}.
  - Expect (0,0) emitted, one `dequeue` pulse, then `err`=1.
  - x, y stay at 0; `move_count`=0; no further `dequeue`.
- **Empty queue**: `finishq`=1 at `start`.
  - Expect (0,0) emitted, zero `dequeue` pulses.
  - Expect `done`=1, `at_goal`=0, `move_count`=0.
- **Reset mid-run**: assert `rst` during MOVE of the 3rd move.
  - Next cycle: IDLE, all outputs at reset values.
  - A subsequent `start` replays correctly from (0,0).
- **Start while busy**: pulse `start` during EMIT.
  - No restart: `move_count` and the emitted sequence are unaffected.
